muldiv_unit: RTL and testbench

//  Multi-cycle integer multiply/divide unit producing the HI/LO pair for MULT/MULTU/DIV/DIVU.

---
 rtl/muldiv_unit_pkg.sv | 20 ++
 rtl/muldiv_unit_if.sv | 36 +++
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared definitions for the multi-cycle multiply/divide unit.
//   - MD_OP_* operation encodings carried on MDOp
//   - md_state_t FSM state encoding (also exported on the debug state signal)
//   - MD_ITER iteration count (equals operand width)
package muldiv_unit_pkg;

    localparam int unsigned MD_ITER = 32;

    localparam logic [1:0] MD_OP_MULT  = 2'b00;
    localparam logic [1:0] MD_OP_MULTU = 2'b01;
    localparam logic [1:0] MD_OP_DIV   = 2'b10;
    localparam logic [1:0] MD_OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'b00,
        MD_ST_CALC = 2'b01,
        MD_ST_DONE = 2'b10
    } md_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: EX-stage request/response bundle for the multiply/divide unit.
//   master (pipeline side) drives: start, MDOp, dInA, dInB, hiWe, loWe, dInWr
//   slave  (muldiv_unit)   drives: busy, done, dOutHi, dOutLo, dbg_state
//
// Handshake: start is a request that is accepted only on a rising edge where
// busy=0; a request seen while busy=1 is dropped (no queueing), so the master
// must hold off until busy falls. Acceptance is implied by busy rising after
// that edge. Completion is signalled by done, a single-cycle pulse during which
// dOutHi/dOutLo already hold the new result. hiWe/loWe are one-cycle write
// strobes, likewise honoured only while busy=0.
interface muldiv_unit_if;

    logic                        start;
    logic [1:0]                  MDOp;
    logic [31:0]                 dInA;
    logic [31:0]                 dInB;
    logic                        hiWe;
    logic                        loWe;
    logic [31:0]                 dInWr;
    logic                        busy;
    logic                        done;
    logic [31:0]                 dOutHi;
    logic [31:0]                 dOutLo;
    muldiv_unit_pkg::md_state_t  dbg_state;

    modport master (
        output start, MDOp, dInA, dInB, hiWe, loWe, dInWr,
        input  busy, done, dOutHi, dOutLo, dbg_state
    );

    modport slave (
        input  start, MDOp, dInA, dInB, hiWe, loWe, dInWr,
        output busy, done, dOutHi, dOutLo, dbg_state
    );

endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any running operation
//   bus  : muldiv_unit_if.slave (start/MDOp/dInA/dInB request, hiWe/loWe/dInWr
//          MTHI/MTLO writes, busy/done status, dOutHi/dOutLo result, dbg_state)
// Operation: start edge latches magnitudes and signs, 32 CALC cycles run one
// shift-add or restoring-divide step each, and the DONE edge writes the
// sign-corrected result into HI/LO and raises done for one cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);

    md_state_t   state, state_next;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic        sign_a, sign_b;
    logic        div0;
    logic [32:0] acc_hi;        // mult: upper product half; div: partial remainder
    logic [31:0] acc_lo;        // mult: multiplier/low product; div: dividend/quotient
    logic [31:0] opd;           // mult: multiplicand; div: divisor
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? neg32(v) : v;
    endfunction

    // Operation-dependent decode of the request and of the latched op.
    logic in_signed, in_div, q_signed, q_div;
    assign in_signed = ~bus.MDOp[0];
    assign in_div    = bus.MDOp[1];
    assign q_signed  = ~op_q[0];
    assign q_div     = op_q[1];

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= MD_ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_ST_IDLE: if (bus.start) state_next = MD_ST_CALC;
            MD_ST_CALC: if (cnt == 5'd0) state_next = MD_ST_DONE;
            MD_ST_DONE: state_next = MD_ST_IDLE;
            default:    state_next = MD_ST_IDLE;
        endcase
    end

    // ---------------- one iteration ----------------
    logic [32:0] step_hi;
    logic [31:0] step_lo;
    logic [32:0] sum;
    logic [32:0] shifted;
    logic        ge;

    always_comb begin
        sum     = {1'b0, acc_hi[31:0]} + (acc_lo[0] ? {1'b0, opd} : 33'd0);
        shifted = {acc_hi[31:0], acc_lo[31]};
        ge      = shifted >= {1'b0, opd};
        if (q_div) begin
            step_hi = ge ? (shifted - {1'b0, opd}) : shifted;
            step_lo = {acc_lo[30:0], ge};
        end else begin
            // Shift the 33-bit sum right together with the low half.
            step_hi = {1'b0, sum[32:1]};
            step_lo = {sum[0], acc_lo[31:1]};
        end
    end

    // ---------------- sign-corrected result ----------------
    logic [63:0] res_prod;
    logic [31:0] res_hi, res_lo;

    always_comb begin
        res_prod = {acc_hi[31:0], acc_lo};
        if (q_signed && (sign_a ^ sign_b)) res_prod = neg64(res_prod);
        if (q_div) begin
            res_lo = (q_signed && (sign_a ^ sign_b)) ? neg32(acc_lo) : acc_lo;
            // Remainder follows the dividend. With a zero divisor every step
            // subtracts nothing, so the remainder is |dInA| and this restores dInA.
            res_hi = (q_signed && sign_a) ? neg32(acc_hi[31:0]) : acc_hi[31:0];
            if (div0) res_lo = 32'hFFFF_FFFF;
        end else begin
            res_hi = res_prod[63:32];
            res_lo = res_prod[31:0];
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 5'd0;
            op_q   <= MD_OP_MULT;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            div0   <= 1'b0;
            acc_hi <= 33'd0;
            acc_lo <= 32'd0;
            opd    <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                MD_ST_IDLE: begin
                    if (bus.hiWe) hi_q <= bus.dInWr;
                    if (bus.loWe) lo_q <= bus.dInWr;
                    if (bus.start) begin
                        op_q   <= bus.MDOp;
                        sign_a <= in_signed & bus.dInA[31];
                        sign_b <= in_signed & bus.dInB[31];
                        div0   <= in_div & (bus.dInB == 32'd0);
                        cnt    <= 5'(MD_ITER - 1);
                        acc_hi <= 33'd0;
                        if (in_div) begin
                            acc_lo <= abs32(bus.dInA, in_signed);
                            opd    <= abs32(bus.dInB, in_signed);
                        end else begin
                            acc_lo <= abs32(bus.dInB, in_signed);
                            opd    <= abs32(bus.dInA, in_signed);
                        end
                    end
                end
                MD_ST_CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - 5'd1;
                end
                MD_ST_DONE: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != MD_ST_IDLE);
    assign bus.done      = done_q;
    assign bus.dOutHi    = hi_q;
    assign bus.dOutLo    = lo_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit (vector table plus hand-written
// sequences for ignored start, ignored MT write, mid-operation reset, MT writes).
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk;
    logic rst;
    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.hiWe  = 1'b0;
        bus.loWe  = 1'b0;
    endtask

    // Launch one operation and count cycles from the start edge to done (-1 if never).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.MDOp  = op;
        bus.dInA  = a;
        bus.dInB  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.dInA  = $urandom;
        bus.dInB  = $urandom;
        lat = -1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (bus.done) lat = k;
        end
    endtask

    int lat;
    int seen_done;
    logic [63:0] exp;
    logic [31:0] hi_before;

    initial begin
        vecs[0]  = '{MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{MD_OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{MD_OP_MULT,  32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE};
        vecs[3]  = '{MD_OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[4]  = '{MD_OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5]  = '{MD_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{MD_OP_DIV,   32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        vecs[7]  = '{MD_OP_DIVU,  32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[8]  = '{MD_OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{MD_OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
        vecs[10] = '{MD_OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[11] = '{MD_OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[12] = '{MD_OP_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};

        rst = 1'b1;
        idle_inputs();
        bus.MDOp  = MD_OP_MULT;
        bus.dInA  = 32'd0;
        bus.dInB  = 32'd0;
        bus.dInWr = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",  {63'd0, bus.busy}, 64'd0);
        check("reset_done",  {63'd0, bus.done}, 64'd0);
        check("reset_hi",    {32'd0, bus.dOutHi}, 64'd0);
        check("reset_lo",    {32'd0, bus.dOutLo}, 64'd0);
        check("reset_state", {62'd0, bus.dbg_state}, {62'd0, MD_ST_IDLE});
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < 13; i++) begin
            exp_q.push_back({vecs[i].hi, vecs[i].lo});
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            exp = exp_q.pop_front();
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d_hi", i), {32'd0, bus.dOutHi}, {32'd0, exp[63:32]});
            check($sformatf("vec%0d_lo", i), {32'd0, bus.dOutLo}, {32'd0, exp[31:0]});
            @(posedge clk); #1;
            check($sformatf("vec%0d_after", i), {62'd0, bus.busy, bus.done}, 64'd0);
        end

        // ---------------- start at +5/+33 and hiWe at +10 ignored ----------------
        hi_before = bus.dOutHi;
        @(negedge clk);
        bus.start = 1'b1; bus.MDOp = MD_OP_DIVU; bus.dInA = 32'd100; bus.dInB = 32'd7;
        @(posedge clk); #1;
        idle_inputs();
        seen_done = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            bus.start = (k == 5 || k == 33);
            bus.hiWe  = (k == 10);
            bus.MDOp  = MD_OP_MULTU;
            bus.dInA  = 32'h0BAD_0BAD;
            bus.dInB  = 32'h0000_0003;
            bus.dInWr = 32'hDEAD_BEEF;
            @(posedge clk); #1;
            idle_inputs();
            if (k == 10) check("busy_hiwe_ignored", {32'd0, bus.dOutHi}, {32'd0, hi_before});
            if (bus.done) begin
                seen_done++;
                check("busy_start_latency", 64'(k), 64'd33);
                check("busy_start_hi", {32'd0, bus.dOutHi}, 64'h2);
                check("busy_start_lo", {32'd0, bus.dOutLo}, 64'hE);
            end
        end
        check("busy_start_done_count", 64'(seen_done), 64'd1);
        check("busy_start_idle", {63'd0, bus.busy}, 64'd0);

        // ---------------- reset mid-operation ----------------
        @(negedge clk);
        bus.start = 1'b1; bus.MDOp = MD_OP_MULTU; bus.dInA = 32'h1234_5678; bus.dInB = 32'h9;
        @(posedge clk); #1;
        idle_inputs();
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_busy", {62'd0, bus.busy, bus.done}, 64'd0);
        check("rst_mid_hilo", {bus.dOutHi, bus.dOutLo}, 64'd0);
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) seen_done++;
        end
        check("rst_mid_no_done", 64'(seen_done), 64'd0);

        // ---------------- MT writes ----------------
        @(negedge clk);
        bus.loWe = 1'b1; bus.dInWr = 32'h0000_CAFE;
        @(posedge clk); #1;
        idle_inputs();
        check("mtlo_idle", {bus.dOutHi, bus.dOutLo}, 64'h0000_0000_0000_CAFE);

        // MTHI in the same cycle as start lands first, then the result replaces it.
        @(negedge clk);
        bus.hiWe = 1'b1; bus.dInWr = 32'h5555_AAAA;
        bus.start = 1'b1; bus.MDOp = MD_OP_MULT; bus.dInA = 32'hFFFFFFFD; bus.dInB = 32'd5;
        @(posedge clk); #1;
        idle_inputs();
        check("mthi_with_start", {bus.dOutHi, bus.dOutLo}, 64'h5555_AAAA_0000_CAFE);
        lat = -1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (bus.done) lat = k;
        end
        check("mthi_with_start_latency", 64'(lat), 64'd33);
        check("mthi_with_start_result", {bus.dOutHi, bus.dOutLo}, 64'hFFFF_FFFF_FFFF_FFF1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
